// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time and holds it until decode consumes it.
// Latency: request accepted -> response -> instr_valid on the next cycle; advance -> new request next cycle.
// Backpressure: imem_req_valid/addr held until imem_req_ready; the held instruction waits for advance.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        advance,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        misalign_fault,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3,
        HOLD  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_reg, pc_nxt;
    logic [31:0] instr_reg;
    logic        capture;
    logic        retire;
    logic        flush_misaligned;

    assign flush_misaligned = (flush_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc_reg <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc_reg <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_reg;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (flush) begin
                    pc_nxt = flush_pc;
                    if (flush_misaligned)    state_nxt = FAULT;
                    else if (imem_req_ready) state_nxt = DROP;
                    else                     state_nxt = REQ;
                end else if (imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_nxt = flush_pc;
                    if (flush_misaligned)    state_nxt = FAULT;
                    else if (imem_rsp_valid) state_nxt = REQ;
                    else                     state_nxt = DROP;
                end else if (imem_rsp_valid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            DROP: begin
                // The response still in flight belongs to the abandoned PC.
                if (flush) begin
                    pc_nxt = flush_pc;
                    if (flush_misaligned)    state_nxt = FAULT;
                    else if (imem_rsp_valid) state_nxt = REQ;
                end else if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_nxt    = flush_pc;
                    state_nxt = flush_misaligned ? FAULT : REQ;
                end else if (advance) begin
                    retire = 1'b1;
                    if (pc_next[1:0] == 2'b00) begin
                        pc_nxt    = pc_next;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = FAULT;
                    end
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= NOP_INSTR;
            pc_out    <= RESET_PC;
        end else if (capture) begin
            instr_reg <= imem_rsp_data;
            pc_out    <= pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_count <= 32'h0000_0000;
        else if (retire) retired_count <= retired_count + 32'h0000_0001;
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc_reg;
    assign instr_valid    = (state == HOLD);
    assign instr_out      = instr_valid ? instr_reg : NOP_INSTR;
    assign misalign_fault = (state == FAULT);

endmodule
